ml_bit_packer: RTL and testbench
================================

# ml_bit_packer

Output-side stage placed directly downstream of `ml_demodulator`. It accepts the demodulator's serial per-bit stream (hard bit plus LLR) through a valid/ready handshake and packs every 8 consecutive bits into one symbol-group word. Completed groups go into a show-ahead FIFO, which presents them to the host/decoder through a second valid/ready handshake. The FIFO absorbs the host's bursty ready pattern (128 cycles on, up to 512 off) without stalling the demodulator more than necessary.

## Interface
- `LLR_W`, 8, width of one signed LLR from the demodulator
- `DEPTH`, 16, FIFO capacity in 8-bit groups; power of 2, at least 2
- `i_clk`  in  1  clock; all state changes on rising edge
- `i_reset_n`  in  1  reset; synchronous, active-low
- `i_clr`  in  1  synchronous clear; discards the partial group and all FIFO contents
- `i_vld`  in  1  bit valid; connects to demodulator `o_rd_vld`
- `o_rdy`  out  1  bit ready; connects to demodulator `i_rd_rdy`
- `i_hard_bit`  in  1  hard decision of the current bit
- `i_llr`  in  LLR_W  LLR of the current bit, two's complement
- `o_vld`  out  1  group valid
- `i_rdy`  in  1  group ready from the consumer
- `o_hb`  out  8  packed hard bits; bit k is the k-th bit received in the group
- `o_llr`  out  8*LLR_W  packed LLRs; slice [k*LLR_W +: LLR_W] is the k-th LLR
- `o_level`  out  $clog2(DEPTH)+1  number of complete groups in the FIFO

## Operation
- Bit accept occurs when `i_vld && o_rdy` at a rising edge.
- On accept, `i_hard_bit` and `i_llr` are written into assembly slot `k`.
- `k` is a 3-bit counter, 0..7. It increments on each accept and wraps 7→0.
- When the accept has `k==7`, the complete group (slots 0–6 plus the incoming bit 7) is pushed into FIFO at the tail on the same edge.
- `o_rdy = (level != DEPTH) && i_reset_n && !i_clr`.
  - o_rdy is combinational from registered level, so a push is never attempted into a full FIFO.
- Pop occurs when `o_vld && i_rdy`. `o_vld = (level != 0)`.
- Show-ahead read: `o_hb` and `o_llr` always reflect the head entry. Both are forced to 0 when `o_vld=0`.
- Simultaneous push and pop: level is unchanged, and pointers advance independently. This case is legal at any level, including DEPTH-1 and 1.
- Pointers are log2(DEPTH) bits and wrap naturally. `level` is a separate counter: +1 on push only, −1 on pop only.
- `i_clr=1`:
  - k, pointers and level go to 0 at the next edge.
  - An accept or pop requested in the same cycle is ignored.
  - `o_rdy=0` during clr.
- Reset (i_reset_n=0 at an edge) has the same effect as clr. Reset has priority over clr.
- LLR values are stored verbatim; no saturation and no sign change.

## Timing
- Reset values after the first edge with i_reset_n=0:
  - o_vld=0, o_hb=0, o_llr=0, o_level=0
  - k=0
  - o_rdy=0 while i_reset_n=0, and 1 in the first cycle after release
- Latency: the 8th bit accepted at edge t into an empty FIFO gives o_vld=1 in the cycle after t, with the full group on o_hb/o_llr.
- Throughput:
  - Input: 1 bit per cycle while not full.
  - Output: 1 group per cycle while non-empty.
  - Sustained balance requires the consumer to pop at least once per 8 input cycles.
- Full: level=DEPTH gives o_rdy=0, including when k≠0. A pop at edge t raises o_rdy in the cycle after t; there is no same-cycle bypass.
- Partial group on reset or clr: the partial group is lost, and no partial word is ever emitted.
- o_vld, once high, stays high with stable data until popped, unless reset or clr occurs.

## Test plan
- Reset then stream bits 1,0,1,1,0,0,1,0 with LLRs 1..8 and i_rdy=1 → one group with o_hb=8'h4D and o_llr slice k = k+1. o_vld rises one cycle after the 8th accept.
- Hold i_rdy=0 and stream 8*DEPTH+3 bits continuously → o_level=16, o_rdy drops exactly after 128 accepts, k=0. The next 3 bits are accepted only after pops. No group is lost or duplicated.
- Host pattern of 128 ready cycles then 512 idle, repeated, with the demodulator model issuing 8 bits per 64 cycles over 8000 bits → all 1000 groups match golden in order, and o_rdy never deasserts (level ≤ 10).
- With the FIFO at level=DEPTH-1 and k=7, accept the 8th bit and pop in the same cycle → level stays DEPTH-1, and head and tail data are both correct.
- Accept 5 bits, then pulse i_clr for one cycle with i_vld=1 → the partial group is discarded and level=0. The next 8 bits form a clean group with bit 0 equal to the first post-clr bit.
- Assert i_reset_n=0 mid-stream with level=7 → on the next edge o_vld=0, o_level=0 and outputs are 0. o_rdy=0 during reset and 1 in the first cycle after release.

Source files
------------

// File: rtl/ml_bit_packer_if.sv
// Bit-stream input and packed-group output handshakes of ml_bit_packer.
// master = demodulator/host side, slave = packer side.
interface ml_bit_packer_if #(
  parameter int LLR_W = 8,
  parameter int DEPTH = 16
);
  logic                       i_vld;
  logic                       o_rdy;
  logic                       i_hard_bit;
  logic [LLR_W-1:0]           i_llr;
  logic                       o_vld;
  logic                       i_rdy;
  logic [7:0]                 o_hb;
  logic [8*LLR_W-1:0]         o_llr;
  logic [$clog2(DEPTH):0]     o_level;

  modport master (
    output i_vld, i_hard_bit, i_llr, i_rdy,
    input  o_rdy, o_vld, o_hb, o_llr, o_level
  );

  modport slave (
    input  i_vld, i_hard_bit, i_llr, i_rdy,
    output o_rdy, o_vld, o_hb, o_llr, o_level
  );
endinterface

// File: rtl/ml_bit_packer.sv
// Packs 8 serial demodulator bits (hard bit + LLR) into one group word and
// buffers completed groups in a show-ahead FIFO towards the host/decoder.
module ml_bit_packer #(
  parameter int LLR_W = 8,
  parameter int DEPTH = 16
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic           i_clr,
  ml_bit_packer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [2:0]          k;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [LW-1:0]       level;
  logic [6:0]          asm_hb;
  logic [7*LLR_W-1:0]  asm_llr;
  logic [7:0]          mem_hb  [DEPTH];
  logic [8*LLR_W-1:0]  mem_llr [DEPTH];
  logic                accept;
  logic                push;
  logic                pop;

  assign bus.o_rdy   = (level != FULL) && i_reset_n && !i_clr;
  assign bus.o_vld   = (level != '0);
  assign bus.o_level = level;
  assign bus.o_hb    = bus.o_vld ? mem_hb[rd_ptr]  : '0;
  assign bus.o_llr   = bus.o_vld ? mem_llr[rd_ptr] : '0;

  assign accept = bus.i_vld && bus.o_rdy;
  assign push   = accept && (k == 3'd7);
  // Pops are suppressed during reset/clear so the pointers stay cleanly zeroed.
  assign pop    = bus.o_vld && bus.i_rdy && i_reset_n && !i_clr;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_clr) begin
      k      <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (accept) k <= k + 3'd1;
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        level <= level + LW'(1);
      else if (pop && !push)
        level <= level - LW'(1);
    end
  end

  // Slot 7 is never stored: the 8th bit goes straight into the FIFO word.
  always_ff @(posedge i_clk) begin
    if (accept && (k != 3'd7)) begin
      for (int s = 0; s < 7; s++) begin
        if (k == 3'(s)) begin
          asm_hb[s]                   <= bus.i_hard_bit;
          asm_llr[s*LLR_W +: LLR_W]   <= bus.i_llr;
        end
      end
    end
    if (push) begin
      mem_hb[wr_ptr]  <= {bus.i_hard_bit, asm_hb};
      mem_llr[wr_ptr] <= {bus.i_llr, asm_llr};
    end
  end
endmodule

// File: tb/tb_ml_bit_packer.sv
// Directed table vectors plus multi-cycle sequences for ml_bit_packer.
module tb_ml_bit_packer;
  localparam int LLR_W = 8;
  localparam int DEPTH = 16;

  logic i_clk = 1'b0;
  logic i_reset_n;
  logic i_clr;

  ml_bit_packer_if #(.LLR_W(LLR_W), .DEPTH(DEPTH)) bus ();

  ml_bit_packer #(.LLR_W(LLR_W), .DEPTH(DEPTH)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clr     (i_clr),
    .bus       (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        vld;
    logic        hb;
    logic [7:0]  llr;
    logic        rdy;
    logic        e_vld;
    logic [7:0]  e_hb;
    logic [63:0] e_llr;
    logic [4:0]  e_lvl;
  } vec_t;

  vec_t tbl [20];
  int n_cmp = 0;
  int n_err = 0;
  int tx_n  = 0;
  int rx_g  = 0;
  int rdy_low = 0;
  int max_lvl = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic gbit(input int n);
    logic [31:0] u;
    u = n;
    return u[0] ^ u[3] ^ u[5];
  endfunction

  function automatic logic [7:0] gllr(input int n);
    return 8'(n * 7 + 3);
  endfunction

  function automatic logic [7:0] ghb(input int g);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = gbit(8 * g + j);
    return r;
  endfunction

  function automatic logic [63:0] gllw(input int g);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = gllr(8 * g + j);
    return r;
  endfunction

  function automatic vec_t mk(input logic vld, input logic hb, input logic [7:0] llr,
                              input logic rdy, input logic e_vld, input logic [7:0] e_hb,
                              input logic [63:0] e_llr, input logic [4:0] e_lvl);
    vec_t v;
    v.vld = vld; v.hb = hb; v.llr = llr; v.rdy = rdy;
    v.e_vld = e_vld; v.e_hb = e_hb; v.e_llr = e_llr; v.e_lvl = e_lvl;
    return v;
  endfunction

  task automatic do_reset();
    i_reset_n = 1'b0;
    i_clr = 1'b0;
    bus.i_vld = 1'b0;
    bus.i_rdy = 1'b0;
    tick();
    i_reset_n = 1'b1;
    tick();
    tx_n = 0;
    rx_g = 0;
  endtask

  // Push up to 'count' bits with the consumer stalled; stops early (mid-cycle)
  // as soon as o_rdy is seen low.
  task automatic feed(input int count, output int acc);
    acc = 0;
    for (int c = 0; c < 400 && acc < count; c++) begin
      bus.i_vld = 1'b1;
      bus.i_rdy = 1'b0;
      bus.i_hard_bit = gbit(tx_n);
      bus.i_llr = gllr(tx_n);
      #1;
      if (!bus.o_rdy) break;
      acc++;
      tx_n++;
      tick();
    end
  endtask

  // mode 0: source always valid, sink always ready.
  // mode 1: 8 bits per 64 cycles, sink ready 128 of every 640 cycles.
  task automatic run_stream(input int nbits, input int mode, input int ngroups, input int limit);
    int cyc;
    logic v, r;
    cyc = 0;
    while (rx_g < ngroups && cyc < limit) begin
      v = (tx_n < nbits) && (mode == 0 || tx_n < 8 * (cyc / 64 + 1));
      r = (mode == 0) ? 1'b1 : ((cyc % 640) < 128);
      bus.i_vld = v;
      bus.i_rdy = r;
      bus.i_hard_bit = gbit(tx_n);
      bus.i_llr = gllr(tx_n);
      #1;
      if (mode == 1) begin
        if (!bus.o_rdy) rdy_low++;
        if (int'(bus.o_level) > max_lvl) max_lvl = int'(bus.o_level);
      end
      if (bus.o_vld && r) begin
        chk($sformatf("grp%0d_hb", rx_g), 64'(bus.o_hb), 64'(ghb(rx_g)));
        chk($sformatf("grp%0d_llr", rx_g), bus.o_llr, gllw(rx_g));
        rx_g++;
      end
      if (v && bus.o_rdy) tx_n++;
      tick();
      cyc++;
    end
    chk("stream_groups_done", 64'(rx_g), 64'(ngroups));
    bus.i_vld = 1'b0;
    bus.i_rdy = 1'b0;
  endtask

  initial begin : main
    logic [7:0] a_bits;
    int acc;
    a_bits = 8'b0100_1101;
    for (int k = 0; k < 8; k++) begin
      tbl[k] = mk(1'b1, a_bits[k], 8'(k + 1), 1'b1, k == 7, (k == 7) ? 8'h4D : 8'h00,
                  (k == 7) ? 64'h0807_0605_0403_0201 : 64'h0, (k == 7) ? 5'd1 : 5'd0);
      tbl[10+k] = mk(1'b1, 1'b1, 8'(8'hFF - k), 1'b0, k == 7, (k == 7) ? 8'hFF : 8'h00,
                     (k == 7) ? 64'hF8F9_FAFB_FCFD_FEFF : 64'h0, (k == 7) ? 5'd1 : 5'd0);
    end
    tbl[8]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'h4D, 64'h0807_0605_0403_0201, 5'd1);
    tbl[9]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 64'h0, 5'd0);
    tbl[18] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hFF, 64'hF8F9_FAFB_FCFD_FEFF, 5'd1);
    tbl[19] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 64'h0, 5'd0);

    // Power-on reset
    i_reset_n = 1'b0;
    i_clr = 1'b0;
    bus.i_vld = 1'b0;
    bus.i_rdy = 1'b0;
    bus.i_hard_bit = 1'b0;
    bus.i_llr = '0;
    tick();
    chk("rst_vld", 64'(bus.o_vld), 64'd0);
    chk("rst_hb", 64'(bus.o_hb), 64'd0);
    chk("rst_llr", bus.o_llr, 64'd0);
    chk("rst_level", 64'(bus.o_level), 64'd0);
    chk("rst_rdy", 64'(bus.o_rdy), 64'd0);
    tick();
    i_reset_n = 1'b1;
    #1;
    chk("rst_release_rdy", 64'(bus.o_rdy), 64'd1);
    tick();

    // Table vectors: two groups, stall, then pop
    for (int i = 0; i < 20; i++) begin
      bus.i_vld = tbl[i].vld;
      bus.i_hard_bit = tbl[i].hb;
      bus.i_llr = tbl[i].llr;
      bus.i_rdy = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_rdy", i), 64'(bus.o_rdy), 64'd1);
      tick();
      chk($sformatf("tbl%0d_vld", i), 64'(bus.o_vld), 64'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_hb", i), 64'(bus.o_hb), 64'(tbl[i].e_hb));
      chk($sformatf("tbl%0d_llr", i), bus.o_llr, tbl[i].e_llr);
      chk($sformatf("tbl%0d_lvl", i), 64'(bus.o_level), 64'(tbl[i].e_lvl));
    end
    bus.i_vld = 1'b0;
    bus.i_rdy = 1'b0;

    // Fill to DEPTH with consumer stalled, then drain the extra bits through
    do_reset();
    feed(8 * DEPTH + 3, acc);
    chk("fill_accepts", 64'(acc), 64'(8 * DEPTH));
    chk("fill_level", 64'(bus.o_level), 64'(DEPTH));
    chk("fill_head_hb", 64'(bus.o_hb), 64'(ghb(0)));
    tick();
    for (int c = 0; c < 3; c++) begin
      bus.i_vld = 1'b1;
      bus.i_rdy = 1'b0;
      #1;
      chk($sformatf("full_rdy%0d", c), 64'(bus.o_rdy), 64'd0);
      tick();
    end
    run_stream(8 * DEPTH + 8, 0, DEPTH + 1, 400);
    chk("fill_drain_vld", 64'(bus.o_vld), 64'd0);
    chk("fill_drain_level", 64'(bus.o_level), 64'd0);

    // Push and pop in the same cycle at DEPTH-1 with k==7
    do_reset();
    feed(8 * (DEPTH - 1) + 7, acc);
    chk("pp_level_before", 64'(bus.o_level), 64'(DEPTH - 1));
    bus.i_vld = 1'b1;
    bus.i_rdy = 1'b1;
    bus.i_hard_bit = gbit(tx_n);
    bus.i_llr = gllr(tx_n);
    #1;
    chk("pp_rdy", 64'(bus.o_rdy), 64'd1);
    chk("pp_head_hb", 64'(bus.o_hb), 64'(ghb(0)));
    chk("pp_head_llr", bus.o_llr, gllw(0));
    tick();
    tx_n++;
    rx_g = 1;
    bus.i_vld = 1'b0;
    bus.i_rdy = 1'b0;
    #1;
    chk("pp_level_after", 64'(bus.o_level), 64'(DEPTH - 1));
    run_stream(8 * DEPTH, 0, DEPTH, 100);

    // Clear with a partial group of 5 and one group queued
    do_reset();
    feed(13, acc);
    chk("clr_level_before", 64'(bus.o_level), 64'd1);
    i_clr = 1'b1;
    bus.i_vld = 1'b1;
    bus.i_rdy = 1'b1;
    #1;
    chk("clr_rdy", 64'(bus.o_rdy), 64'd0);
    tick();
    i_clr = 1'b0;
    bus.i_vld = 1'b0;
    bus.i_rdy = 1'b0;
    #1;
    chk("clr_level", 64'(bus.o_level), 64'd0);
    chk("clr_vld", 64'(bus.o_vld), 64'd0);
    chk("clr_hb", 64'(bus.o_hb), 64'd0);
    tick();
    tx_n = 40;
    rx_g = 5;
    run_stream(48, 0, 6, 100);

    // Reset mid-stream at level 7 with a partial group
    do_reset();
    feed(59, acc);
    chk("mrst_level_before", 64'(bus.o_level), 64'd7);
    i_reset_n = 1'b0;
    bus.i_vld = 1'b1;
    bus.i_rdy = 1'b1;
    #1;
    chk("mrst_rdy_during", 64'(bus.o_rdy), 64'd0);
    tick();
    chk("mrst_vld", 64'(bus.o_vld), 64'd0);
    chk("mrst_level", 64'(bus.o_level), 64'd0);
    chk("mrst_hb", 64'(bus.o_hb), 64'd0);
    chk("mrst_llr", bus.o_llr, 64'd0);
    chk("mrst_rdy_held", 64'(bus.o_rdy), 64'd0);
    tick();
    i_reset_n = 1'b1;
    bus.i_vld = 1'b0;
    bus.i_rdy = 1'b0;
    #1;
    chk("mrst_rdy_release", 64'(bus.o_rdy), 64'd1);
    tick();
    chk("mrst_no_partial", 64'(bus.o_vld), 64'd0);
    tx_n = 0;
    rx_g = 0;
    run_stream(8, 0, 1, 50);

    // Bursty host against a paced demodulator
    do_reset();
    rdy_low = 0;
    max_lvl = 0;
    run_stream(8000, 1, 1000, 70000);
    chk("burst_rdy_low_cycles", 64'(rdy_low), 64'd0);
    chk("burst_level_le_10", 64'(max_lvl <= 10), 64'd1);
    chk("burst_end_level", 64'(bus.o_level), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
